// File: rtl/jfive_wb_rr_arbiter.sv
// jfive_wb_rr_arbiter: round-robin Wishbone arbiter with optional ack timeout
module jfive_wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADR_WIDTH      = 24,
    parameter int DAT_WIDTH      = 32,
    parameter int SEL_WIDTH      = DAT_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cke,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [NUM_MASTERS*DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic [NUM_MASTERS-1:0]         s_wb_we_i,
    input  logic [NUM_MASTERS-1:0]         s_wb_stb_i,
    output logic [NUM_MASTERS-1:0]         s_wb_ack_o,
    output logic [ADR_WIDTH-1:0]           m_wb_adr_o,
    output logic [DAT_WIDTH-1:0]           m_wb_dat_o,
    input  logic [DAT_WIDTH-1:0]           m_wb_dat_i,
    output logic [SEL_WIDTH-1:0]           m_wb_sel_o,
    output logic                           m_wb_we_o,
    output logic                           m_wb_stb_o,
    input  logic                           m_wb_ack_i,
    output logic [NUM_MASTERS-1:0]         grant_o,
    output logic                           timeout_o
);
    localparam int GW = NUM_MASTERS > 2 ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    logic [0:0] state;
    logic [GW-1:0] g, last_grant, next_g;
    logic [CW-1:0] cnt;
    logic active, to_hit;
    // unrolled per last_grant so every stb index is a constant
    always_comb begin
        next_g = last_grant;
        for (int l = 0; l < NUM_MASTERS; l++)
            if (last_grant == GW'(l))
                for (int i = NUM_MASTERS; i >= 1; i--)
                    if (s_wb_stb_i[(l + i) % NUM_MASTERS]) next_g = GW'((l + i) % NUM_MASTERS);
    end
    // masking with reset keeps a transfer aborted by reset from ever acking
    assign active = (state == BUSY) && reset;
    assign to_hit = (TIMEOUT_CYCLES > 0) && active && cke && !m_wb_ack_i && (int'(cnt) == TIMEOUT_CYCLES - 1);
    assign timeout_o  = to_hit;
    assign m_wb_stb_o = active && s_wb_stb_i[g] && !to_hit;
    assign m_wb_we_o  = active && s_wb_we_i[g];
    assign m_wb_adr_o = active ? s_wb_adr_i[g*ADR_WIDTH +: ADR_WIDTH] : '0;
    assign m_wb_dat_o = active ? s_wb_dat_i[g*DAT_WIDTH +: DAT_WIDTH] : '0;
    assign m_wb_sel_o = active ? s_wb_sel_i[g*SEL_WIDTH +: SEL_WIDTH] : '0;
    assign grant_o    = active ? NUM_MASTERS'(1) << g : '0;
    always_comb begin
        s_wb_ack_o = '0;
        s_wb_dat_o = '0;
        if (active) begin
            s_wb_ack_o[g] = m_wb_ack_i || to_hit;
            s_wb_dat_o[g*DAT_WIDTH +: DAT_WIDTH] = to_hit ? '0 : m_wb_dat_i;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            g          <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            cnt        <= '0;
        end else if (cke) begin
            if (state == IDLE) begin
                if (|s_wb_stb_i) begin
                    state <= BUSY;
                    g     <= next_g;
                    cnt   <= '0;
                end
            end else if (m_wb_ack_i || to_hit) begin
                state      <= IDLE;
                last_grant <= g;
            end else if (!s_wb_stb_i[g]) begin
                state <= IDLE;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
